// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg
//  Shared types and helpers for the multi-channel clock divider.
//  - DIV_MAX_PKG / DIV_W : widest supported divisor and the field width that holds it
//    (DIV_W = $clog2(DIV_MAX+1), so DIV_MAX itself is representable).
//  - clkdiv_cfg_t        : one channel configuration {div, high, phase}.
//  - norm_cfg()          : duty/phase clamps applied when a config becomes active.
package clkdiv_pkg;

  function automatic int div_w(input int div_max);
    return $clog2(div_max + 1);
  endfunction

  // Field width is fixed here because packed structs cannot be parameterised;
  // the top-level DIV_MAX must not exceed DIV_MAX_PKG.
  localparam int DIV_MAX_PKG = 256;
  localparam int DIV_W       = div_w(DIV_MAX_PKG);

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] high;
    logic [DIV_W-1:0] phase;
  } clkdiv_cfg_t;

  // Guarantees at least one high and one low cycle per period for any legal div:
  //  high==0   -> 50% (div>>1)
  //  high>=div -> div-1
  //  phase>=div -> 0
  function automatic clkdiv_cfg_t norm_cfg(input clkdiv_cfg_t c);
    clkdiv_cfg_t r;
    r = c;
    if (c.high == '0)
      r.high = c.div >> 1;
    else if (c.high >= c.div)
      r.high = c.div - DIV_W'(1);
    if (c.phase >= c.div)
      r.phase = '0;
    return r;
  endfunction

endpackage

// File: rtl/clkdiv_ch.sv
// clkdiv_ch
//  One divider channel: shadow config + pending flag, active config, period
//  counter and registered clk_o / ce_o.
//  Ports:
//   clk, rst_n  clock, async active-low reset
//   en          run enable; low holds cnt at the active phase, outputs low
//   sync        restart at phase (takes priority over wrap)
//   wr          accepted, legal config write addressed to this channel
//   wr_cfg      raw (un-normalised) config payload
//   pending     shadow holds a config not yet applied
//   clk_o       divided clock, registered
//   ce_o        1-cycle strobe on the cycle clk_o rises (cnt_n == 0)
module clkdiv_ch
  import clkdiv_pkg::*;
#(
  parameter int DIV_RST = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sync,
  input  logic        wr,
  input  clkdiv_cfg_t wr_cfg,
  output logic        pending,
  output logic        clk_o,
  output logic        ce_o
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam clkdiv_cfg_t ACT_RST =
    norm_cfg({DIV_W'(DIV_RST), {DIV_W{1'b0}}, {DIV_W{1'b0}}});

  clkdiv_cfg_t      shadow, act, nxt_cfg;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic             wrap, apply;

  assign wrap  = (cnt == act.div - ONE);
  // Shadow goes live only at a period boundary, a sync, or while stopped,
  // so a running clock never sees a mid-period shape change.
  assign apply = pending & (wrap | sync | ~en);

  always_comb begin
    nxt_cfg = apply ? norm_cfg(shadow) : act;
    if (apply || !en || sync)
      cnt_n = nxt_cfg.phase;
    else if (wrap)
      cnt_n = '0;
    else
      cnt_n = cnt + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      act     <= ACT_RST;
      pending <= 1'b0;
      cnt     <= '0;
      clk_o   <= 1'b0;
      ce_o    <= 1'b0;
    end else begin
      act <= nxt_cfg;
      cnt <= cnt_n;
      // A write landing on the apply cycle wins: it refills the shadow and
      // keeps pending set for the next boundary.
      if (wr) begin
        shadow  <= wr_cfg;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
      clk_o <= en & (cnt_n < nxt_cfg.high);
      ce_o  <= en & (cnt_n == '0);
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi
//  N-channel programmable clock divider producing divided clocks and
//  clock-enable strobes from clk. Each channel has divisor, high time and
//  phase; new configs sit in a per-channel shadow until a period boundary.
//  Ports:
//   clk, rst_n   system clock, async active-low reset
//   en[N_CH]     per-channel run enable
//   sync_i       1-cycle pulse, restart all enabled channels at their phase
//   cfg_valid    config write request; cfg_ready = !pending[cfg_ch]
//   cfg_ch       target channel
//   cfg_div      divisor, legal 2..DIV_MAX
//   cfg_high     high cycles per period (0 = 50%)
//   cfg_phase    counter start value
//   cfg_err      1-cycle pulse after an illegal divisor was rejected
//   clk_o[N_CH]  divided clocks
//   ce_o[N_CH]   strobes coincident with clk_o rising
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int DIV_MAX = DIV_MAX_PKG,
  parameter  int DIV_RST = 8,
  localparam int CH_W    = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             sync_i,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_high,
  input  logic [DIV_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic [N_CH-1:0]  clk_o,
  output logic [N_CH-1:0]  ce_o
);

  localparam logic [DIV_W-1:0] DIV_LO = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_HI = DIV_W'(DIV_MAX);

  logic [N_CH-1:0] pending, wr;
  logic            xfer, legal;
  clkdiv_cfg_t     wr_cfg;

  assign cfg_ready = ~pending[cfg_ch];
  assign xfer      = cfg_valid & cfg_ready;
  assign legal     = (cfg_div >= DIV_LO) && (cfg_div <= DIV_HI);
  assign wr_cfg    = '{div: cfg_div, high: cfg_high, phase: cfg_phase};

  // An illegal divisor still completes the handshake; it is simply dropped
  // and flagged one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= xfer & ~legal;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr[i] = xfer & legal & (cfg_ch == CH_W'(i));

    clkdiv_ch #(.DIV_RST(DIV_RST)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[i]),
      .sync    (sync_i),
      .wr      (wr[i]),
      .wr_cfg  (wr_cfg),
      .pending (pending[i]),
      .clk_o   (clk_o[i]),
      .ce_o    (ce_o[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: a position-in-period model (position = phase +
// cycles since last restart, mod div) checked every cycle, plus directed
// literal expectations for duty, period, lag, clamps and reset.
module tb_clkdiv_multi;
  import clkdiv_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       en = '0;
  logic             sync_i = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0, cfg_high = '0, cfg_phase = '0;
  logic             cfg_err;
  logic [3:0]       clk_o, ce_o;

  int total = 0;
  int bad = 0;

  clkdiv_multi #(.N_CH(4), .DIV_MAX(256), .DIV_RST(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_i(sync_i),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_err(cfg_err), .clk_o(clk_o), .ce_o(ce_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int  m_div[4]    = '{8, 8, 8, 8};
  int  m_high[4]   = '{4, 4, 4, 4};
  int  m_ph[4]     = '{0, 0, 0, 0};
  int  m_anchor[4] = '{0, 0, 0, 0};
  int  s_div[4], s_high[4], s_ph[4];
  bit  m_pend[4]   = '{0, 0, 0, 0};
  int  t = 0;
  bit [3:0] exp_clk = '0, exp_ce = '0;
  bit       exp_err = 1'b0;

  function automatic int pos(input int i, input int tt);
    return (m_ph[i] + tt - m_anchor[i]) % m_div[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_div[i] = 8; m_high[i] = 4; m_ph[i] = 0; m_anchor[i] = t; m_pend[i] = 0;
      end
      exp_clk = '0; exp_ce = '0; exp_err = 1'b0;
    end else begin
      bit xfer, legal;
      xfer  = cfg_valid && !m_pend[cfg_ch];
      legal = (cfg_div >= 2) && (cfg_div <= 256);
      for (int i = 0; i < 4; i++) begin
        int cur, nxt, d, h;
        bit ap;
        cur = pos(i, t);
        ap  = m_pend[i] && (cur == m_div[i] - 1 || sync_i || !en[i]);
        if (ap) begin
          d = s_div[i];
          h = s_high[i];
          m_div[i]  = d;
          m_high[i] = (h == 0) ? d / 2 : ((h >= d) ? d - 1 : h);
          m_ph[i]   = (s_ph[i] >= d) ? 0 : s_ph[i];
          m_anchor[i] = t + 1;
          m_pend[i] = 0;
        end else if (!en[i] || sync_i) begin
          m_anchor[i] = t + 1;
        end
        if (xfer && legal && cfg_ch == i) begin
          s_div[i] = cfg_div; s_high[i] = cfg_high; s_ph[i] = cfg_phase;
          m_pend[i] = 1;
        end
        nxt = pos(i, t + 1);
        exp_clk[i] = en[i] && (nxt < m_high[i]);
        exp_ce[i]  = en[i] && (nxt == 0);
      end
      exp_err = xfer && !legal;
      t++;
    end
  end

  always @(negedge clk) begin
    check("clk_o", 32'(clk_o), 32'(exp_clk));
    check("ce_o", 32'(ce_o), 32'(exp_ce));
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write_cfg(input int ch, input int d, input int h, input int p);
    int k = 0;
    cfg_ch = 2'(ch);
    while (!cfg_ready && k < 20) begin tick(); k++; end
    check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_div = DIV_W'(d); cfg_high = DIV_W'(h); cfg_phase = DIV_W'(p);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic measure(input int ch, input int n, output int hi, output int ce);
    hi = 0; ce = 0;
    for (int j = 0; j < n; j++) begin
      hi += int'(clk_o[ch]);
      ce += int'(ce_o[ch]);
      tick();
    end
  endtask

  task automatic sync_pulse();
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi, ce, other, k, f0, f1;

    // reset state
    repeat (3) tick();
    check("rst_clk_o", 32'(clk_o), 32'd0);
    check("rst_ce_o", 32'(ce_o), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // 1: DIV_RST=8 on ch0 only
    rst_n = 1'b1;
    en = 4'b0001;
    repeat (8) tick();
    hi = 0; ce = 0; other = 0;
    for (int j = 0; j < 16; j++) begin
      hi += int'(clk_o[0]);
      ce += int'(ce_o[0]);
      other += int'(|{clk_o[3:1], ce_o[3:1]});
      tick();
    end
    check("t1_high", hi, 8);
    check("t1_ce", ce, 2);
    check("t1_idle_ch", other, 0);

    // 2: div=5, 50% duty, deferred to period boundary
    write_cfg(0, 5, 0, 0);
    check("t2_ready_low", 32'(cfg_ready), 32'd0);
    k = 0;
    while (!cfg_ready && k < 12) begin tick(); k++; end
    check("t2_applied", 32'(cfg_ready), 32'd1);
    measure(0, 10, hi, ce);
    check("t2_high", hi, 4);
    check("t2_ce", ce, 2);

    // 3: illegal divisors rejected, boundaries accepted
    write_cfg(0, 1, 0, 0);
    check("t3_err_lo", 32'(cfg_err), 32'd1);
    check("t3_ready_lo", 32'(cfg_ready), 32'd1);
    tick();
    check("t3_err_clr", 32'(cfg_err), 32'd0);
    write_cfg(0, 257, 0, 0);
    check("t3_err_hi", 32'(cfg_err), 32'd1);
    check("t3_ready_hi", 32'(cfg_ready), 32'd1);
    tick();
    measure(0, 10, hi, ce);
    check("t3_high_kept", hi, 4);
    check("t3_ce_kept", ce, 2);
    write_cfg(2, 256, 0, 0);
    check("t3_err_max", 32'(cfg_err), 32'd0);
    write_cfg(3, 2, 0, 0);
    check("t3_err_min", 32'(cfg_err), 32'd0);
    tick();

    // 4: phase offset of 3 between ch0 and ch1, repeatable across syncs
    en = 4'b0011;
    tick();
    write_cfg(0, 6, 0, 0);
    write_cfg(1, 6, 0, 3);
    for (int r = 0; r < 2; r++) begin
      sync_pulse();
      f0 = -1; f1 = -1;
      for (int j = 0; j < 12; j++) begin
        if (ce_o[0] && f0 < 0) f0 = j;
        if (ce_o[1] && f1 < 0) f1 = j;
        tick();
      end
      check("t4_ch0_first_ce", f0, 0);
      check("t4_ch1_first_ce", f1, 3);
      repeat (7) tick();
    end

    // 5: high and phase clamps
    write_cfg(0, 4, 9, 0);
    sync_pulse();
    measure(0, 8, hi, ce);
    check("t5_high_clamp", hi, 6);
    check("t5_ce", ce, 2);
    write_cfg(0, 4, 0, 7);
    sync_pulse();
    check("t5_phase_clamp_ce", 32'(ce_o[0]), 32'd1);
    measure(0, 8, hi, ce);
    check("t5_high_50", hi, 4);
    check("t5_ce2", ce, 2);

    // 6: async reset with a pending write
    write_cfg(0, 10, 0, 0);
    check("t6_pending", 32'(cfg_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_clk", 32'(clk_o), 32'd0);
    check("t6_async_ce", 32'(ce_o), 32'd0);
    check("t6_async_ready", 32'(cfg_ready), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    en = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      cfg_ch = 2'(c);
      #1 check("t6_ready_all", 32'(cfg_ready), 32'd1);
    end
    cfg_ch = 2'd0;
    repeat (8) tick();
    measure(0, 16, hi, ce);
    check("t6_high_rst", hi, 8);
    check("t6_ce_rst", ce, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
